alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor of the single-cycle datapath ALU. It executes one operation per transaction over a WIDTH-bit datapath. Shifts and rotates take a variable amount and run one bit per cycle; an optional multiply runs as shift-add. It sits between the register file operand muxes and the writeback path and holds each result and its flags until the consumer takes them.

## Interface
- WIDTH, 32: datapath width. Must be a power of two, ≥ 8.
- SHW, $clog2(WIDTH): localparam, width of the shift amount.
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block idle and able to accept
- op  input  5  operation code, see Operation
- input_a  input  WIDTH  operand A
- input_b  input  WIDTH  operand B; bits [SHW-1:0] are the shift amount for shift/rotate ops
- cin  input  1  carry-in for ADC
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- alu_out  output  WIDTH  result
- flags  output  4  {Z, C, N, V}

## Operation
- Opcodes:
  - 0 PASS A; 1 PASS B; 2 NOT A; 3 NOT B.
  - 4 ADD; 5 ADC (A+B+cin); 6 SUB (A−B).
  - 7 AND; 8 OR; 9 XOR; 10 NAND.
  - 11 LSL; 12 LSR; 13 ASR; 14 ROL; 15 ROR. Amount k = input_b[SHW-1:0].
  - 16 MUL: low WIDTH bits of the unsigned product.
  - 17–31 reserved.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE).
  - Acceptance occurs when in_valid && in_ready. op, operands and cin are latched at acceptance; later input changes have no effect.
- IDLE → DONE on acceptance for single-cycle ops: 0–10, shifts/rotates with k = 0, and reserved opcodes.
- IDLE → BUSY on acceptance for shifts/rotates with k ≥ 1 and for MUL.
  - Shifts: the counter loads k; each BUSY cycle shifts one bit and decrements; BUSY → DONE when the counter reaches 0.
  - MUL: the counter loads WIDTH; one shift-add step per cycle.
- On entering DONE, alu_out and flags are registered. DONE → IDLE on out_valid && out_ready.
- Z = (result == 0). N = result[WIDTH-1].
- C:
  - ADD/ADC: carry out of bit WIDTH-1.
  - SUB: 1 iff A ≥ B unsigned (no borrow).
  - Shift/rotate, k ≥ 1: last bit shifted out (for rotates, the bit that wrapped).
  - All other ops, including k = 0: C keeps its previous value.
- V:
  - ADD/ADC: A and B have the same sign and the result sign differs.
  - SUB: A and B have different signs and the result sign differs from A.
  - MUL: 1 iff the upper WIDTH bits of the full product are nonzero.
  - All others: 0.
- MUL forces C = 0.
- Reserved opcodes: result 0, Z = 1, N = 0, V = 0, C kept.
- ASR fills with the original A[WIDTH-1] on every step.
- flags persist across transactions, because C is a carried value.

## Timing
- Reset, while reset_n is low and immediately after release:
  - state IDLE, alu_out 0, flags 0, out_valid 0, counter 0.
  - in_ready reads 1, but no acceptance occurs while reset_n is low.
- Latency is counted in rising edges from the acceptance edge to the first cycle out_valid is high:
  - single-cycle ops: 1
  - shift/rotate with k ≥ 1: k + 1
  - MUL: WIDTH + 1
- out_valid is high only in DONE. alu_out and flags are stable for the whole time out_valid is high.
- Backpressure: DONE persists while out_ready is low. in_ready is 0 in BUSY and DONE, and in_valid is ignored.
- Throughput: after the result handshake, in_ready rises the next cycle. No acceptance happens in the same cycle as the result handshake.
- Reset asserted mid-BUSY or mid-DONE aborts the operation immediately; the partial result is discarded and all outputs take their reset values.

## Configuration
- ALU_MUL_EN defined: op 16 uses the shift-add multiplier, with WIDTH BUSY cycles plus a 2·WIDTH-bit accumulator.
- ALU_MUL_EN undefined: no multiplier logic is built. Op 16 behaves as a reserved opcode: latency 1, result 0, Z = 1.

## Test plan
- ADD, WIDTH = 32: 0xFFFFFFFF + 0x00000001 → alu_out 0x00000000, flags Z=1 C=1 N=0 V=0. out_valid one edge after acceptance.
- SUB: 0x80000000 − 0x00000001 → 0x7FFFFFFF, flags Z=0 C=1 N=0 V=1. Then ADC with cin=1: 0x7FFFFFFF + 0 → 0x80000000, V=1, N=1.
- Shifts:
  - ASR 0x80000010 by k=4 → 0xF8000001, C=0, out_valid at edge 5.
  - ROL 0x80000001 by k=1 → 0x00000003, C=1.
  - LSL with k=0 → A unchanged, C unchanged, latency 1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid while driving in_valid=1 with new operands. alu_out and flags stay constant, in_ready=0, and nothing is accepted until one cycle after the handshake.
- MUL (ALU_MUL_EN): 0x00010000 × 0x00010000 → 0x00000000, flags Z=1 C=0 V=1, latency 33. 0x0000FFFF × 0x00000003 → 0x0002FFFD, V=0. Without the macro, op 16 returns 0 with latency 1.
- Reset mid-operation: pull reset_n low 10 cycles into a MUL. out_valid=0, flags=0, alu_out=0 and in_ready=1 after release. A subsequent ADD 2+3 returns 5 with flags 0000.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU over a WIDTH-bit datapath.
//
// Accepts one operation at a time (in_valid/in_ready), executes it, and holds
// the result and flags until the consumer takes them (out_valid/out_ready).
// Logic and arithmetic ops finish in one cycle. Shifts and rotates move one
// bit per cycle. The optional multiplier does one shift-add step per cycle.
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  request handshake (in_ready high only when idle)
//   op                  5-bit operation code
//   input_a, input_b    operands; input_b[SHW-1:0] is the shift amount
//   cin                 carry-in for ADC
//   out_valid, out_ready  result handshake
//   alu_out, flags      result and {Z, C, N, V}
//
// Configuration macro:
//   ALU_MUL_EN  builds the shift-add multiplier for op 16. When undefined,
//               op 16 is treated as a reserved opcode.

module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = SHW + 1;

  localparam logic [4:0] OP_PASS_A = 5'd0;
  localparam logic [4:0] OP_PASS_B = 5'd1;
  localparam logic [4:0] OP_NOT_A  = 5'd2;
  localparam logic [4:0] OP_NOT_B  = 5'd3;
  localparam logic [4:0] OP_ADD    = 5'd4;
  localparam logic [4:0] OP_ADC    = 5'd5;
  localparam logic [4:0] OP_SUB    = 5'd6;
  localparam logic [4:0] OP_AND    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_XOR    = 5'd9;
  localparam logic [4:0] OP_NAND   = 5'd10;
  localparam logic [4:0] OP_LSL    = 5'd11;
  localparam logic [4:0] OP_LSR    = 5'd12;
  localparam logic [4:0] OP_ASR    = 5'd13;
  localparam logic [4:0] OP_ROL    = 5'd14;
  localparam logic [4:0] OP_ROR    = 5'd15;
`ifdef ALU_MUL_EN
  localparam logic [4:0] OP_MUL    = 5'd16;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_next;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic [SHW-1:0]   amount;
  logic             is_shift;
  logic             is_mul;
  logic             start_busy;
  logic             last_step;
  logic             busy_mul;

  logic [WIDTH-1:0] sc_result;
  logic             sc_c;
  logic             sc_v;
  logic [WIDTH:0]   sum_ext;

  logic [WIDTH-1:0] step_work;
  logic             step_c;

`ifdef ALU_MUL_EN
  // Low half holds the remaining multiplier bits, high half the partial sum.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     mul_sum;
`endif

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign amount     = input_b[SHW-1:0];
  assign is_shift   = (op >= OP_LSL) && (op <= OP_ROR);
`ifdef ALU_MUL_EN
  assign is_mul     = (op == OP_MUL);
  assign busy_mul   = (op_q == OP_MUL);
`else
  assign is_mul     = 1'b0;
  assign busy_mul   = 1'b0;
`endif
  assign start_busy = (is_shift && (amount != '0)) || is_mul;
  assign last_step  = (state == BUSY) && (cnt == CNT_W'(1));

  // Single-cycle result straight from the live operands; only used on the
  // acceptance edge. Shift ops land here only with a zero amount.
  always_comb begin
    sc_result = '0;
    sc_c      = flags[2];
    sc_v      = 1'b0;
    sum_ext   = '0;
    case (op)
      OP_PASS_A: sc_result = input_a;
      OP_PASS_B: sc_result = input_b;
      OP_NOT_A:  sc_result = ~input_a;
      OP_NOT_B:  sc_result = ~input_b;
      OP_ADD, OP_ADC: begin
        sum_ext   = {1'b0, input_a} + {1'b0, input_b}
                  + {{WIDTH{1'b0}}, (op == OP_ADC) && cin};
        sc_result = sum_ext[WIDTH-1:0];
        sc_c      = sum_ext[WIDTH];
        sc_v      = (input_a[WIDTH-1] == input_b[WIDTH-1])
                 && (sc_result[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_SUB: begin
        sum_ext   = {1'b0, input_a} - {1'b0, input_b};
        sc_result = sum_ext[WIDTH-1:0];
        sc_c      = ~sum_ext[WIDTH];
        sc_v      = (input_a[WIDTH-1] != input_b[WIDTH-1])
                 && (sc_result[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_AND:  sc_result = input_a & input_b;
      OP_OR:   sc_result = input_a | input_b;
      OP_XOR:  sc_result = input_a ^ input_b;
      OP_NAND: sc_result = ~(input_a & input_b);
      OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: sc_result = input_a;
      default: sc_result = '0;
    endcase
  end

  // One-bit shift/rotate step. ASR re-uses the MSB of the working value,
  // which never changes under ASR, so it always equals the original sign.
  always_comb begin
    step_work = work;
    step_c    = 1'b0;
    case (op_q)
      OP_LSL: begin
        step_work = {work[WIDTH-2:0], 1'b0};
        step_c    = work[WIDTH-1];
      end
      OP_LSR: begin
        step_work = {1'b0, work[WIDTH-1:1]};
        step_c    = work[0];
      end
      OP_ASR: begin
        step_work = {work[WIDTH-1], work[WIDTH-1:1]};
        step_c    = work[0];
      end
      OP_ROL: begin
        step_work = {work[WIDTH-2:0], work[WIDTH-1]};
        step_c    = work[WIDTH-1];
      end
      OP_ROR: begin
        step_work = {work[0], work[WIDTH-1:1]};
        step_c    = work[0];
      end
      default: begin
        step_work = work;
        step_c    = 1'b0;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  // Shift-add step: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, work} : '0);
    acc_next = {mul_sum, acc[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = start_busy ? BUSY : DONE;
      BUSY: if (cnt == CNT_W'(1)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      work    <= '0;
      cnt     <= '0;
      alu_out <= '0;
      flags   <= '0;
`ifdef ALU_MUL_EN
      acc     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= op;
            work <= input_a;
            if (start_busy) begin
              cnt <= {1'b0, amount};
`ifdef ALU_MUL_EN
              if (is_mul) begin
                cnt <= CNT_W'(WIDTH);
                acc <= {{WIDTH{1'b0}}, input_b};
              end
`endif
            end else begin
              alu_out <= sc_result;
              flags   <= {sc_result == '0, sc_c, sc_result[WIDTH-1], sc_v};
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (busy_mul) begin
`ifdef ALU_MUL_EN
            acc <= acc_next;
            if (last_step) begin
              alu_out <= acc_next[WIDTH-1:0];
              flags   <= {acc_next[WIDTH-1:0] == '0, 1'b0, acc_next[WIDTH-1],
                          |acc_next[2*WIDTH-1:WIDTH]};
            end
`endif
          end else begin
            work <= step_work;
            if (last_step) begin
              alu_out <= step_work;
              flags   <= {step_work == '0, step_c, step_work[WIDTH-1], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH = 32).
// The driver pushes hand-computed expectations when an operation is accepted;
// a monitor pops and compares each time a new result is presented.

module tb_alu_seq;

  localparam int WIDTH = 32;

  localparam logic [4:0] PASS_A = 5'd0,  PASS_B = 5'd1,  NOT_A = 5'd2,  NOT_B = 5'd3;
  localparam logic [4:0] ADD = 5'd4,  ADC = 5'd5,  SUB = 5'd6;
  localparam logic [4:0] AND_OP = 5'd7,  OR_OP = 5'd8,  XOR_OP = 5'd9,  NAND_OP = 5'd10;
  localparam logic [4:0] LSL = 5'd11, LSR = 5'd12, ASR = 5'd13, ROL = 5'd14, ROR = 5'd15;
  localparam logic [4:0] MUL = 5'd16, RSVD = 5'd20;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       op = '0;
  logic [WIDTH-1:0] input_a = '0;
  logic [WIDTH-1:0] input_b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       flags;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  logic prev_valid = 1'b0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .input_a   (input_a),
    .input_b   (input_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .flags     (flags)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input string name, input logic [31:0] res,
                              input logic [3:0] flg, input int lat);
    exp_t e;
    e.name = name;
    e.res  = res;
    e.flg  = flg;
    e.lat  = lat;
    e.acc  = cycle;
    exp_q.push_back(e);
  endtask

  task automatic waitIdle(input string name);
    int waited = 0;
    @(negedge clock);
    while (!in_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) checkOutput({name, " in_ready timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Issues one operation and records its expected response at the acceptance edge.
  task automatic applyStimulus(input string name, input logic [4:0] o,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic c, input logic [31:0] exp_res,
                               input logic [3:0] exp_flg, input int exp_lat);
    waitIdle(name);
    if (!in_ready) return;
    op       = o;
    input_a  = a;
    input_b  = b;
    cin      = c;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    pushExpected(name, exp_res, exp_flg, exp_lat);
    in_valid = 1'b0;
  endtask

  // Monitor: compares each newly presented result against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected result", alu_out, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.name, " result"}, alu_out, e.res);
        checkOutput({e.name, " flags"}, 32'(flags), 32'(e.flg));
        checkOutput({e.name, " latency"}, 32'(cycle - e.acc + 1), 32'(e.lat));
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    int waited;

    // Reset state, while asserted and right after release.
    repeat (2) @(negedge clock);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset alu_out", alu_out, 32'd0);
    checkOutput("reset flags", 32'(flags), 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("post-reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

    // Arithmetic.
    applyStimulus("add wrap", ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1100, 1);
    applyStimulus("sub ovf", SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0101, 1);
    applyStimulus("adc cin", ADC, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 4'b0011, 1);

    // Shifts and rotates.
    applyStimulus("asr k4", ASR, 32'h8000_0010, 32'd4, 1'b0, 32'hF800_0001, 4'b0010, 5);
    applyStimulus("rol k1", ROL, 32'h8000_0001, 32'd1, 1'b0, 32'h0000_0003, 4'b0100, 2);
    applyStimulus("lsl k0", LSL, 32'h1234_5678, 32'd0, 1'b0, 32'h1234_5678, 4'b0100, 1);
    applyStimulus("lsr k4", LSR, 32'h0000_00F0, 32'd4, 1'b0, 32'h0000_000F, 4'b0000, 5);
    applyStimulus("ror k1", ROR, 32'h0000_0001, 32'd1, 1'b0, 32'h8000_0000, 4'b0110, 2);

    // Logic and pass ops keep C.
    applyStimulus("and", AND_OP, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 4'b0110, 1);
    applyStimulus("xor", XOR_OP, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, 32'h0000_0000, 4'b1100, 1);
    applyStimulus("or", OR_OP, 32'h00FF_0000, 32'h0000_00FF, 1'b0, 32'h00FF_00FF, 4'b0100, 1);
    applyStimulus("not a", NOT_A, 32'h0000_0000, 32'h1234_0000, 1'b0, 32'hFFFF_FFFF, 4'b0110, 1);
    applyStimulus("nand", NAND_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 4'b1100, 1);
    applyStimulus("pass b", PASS_B, 32'h1111_1111, 32'h0000_0080, 1'b0, 32'h0000_0080, 4'b0100, 1);
    applyStimulus("not b", NOT_B, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 4'b1100, 1);
    applyStimulus("pass a", PASS_A, 32'h8000_0000, 32'h0000_0003, 1'b0, 32'h8000_0000, 4'b0110, 1);
    applyStimulus("reserved", RSVD, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0000_0000, 4'b1100, 1);
    applyStimulus("sub borrow", SUB, 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 4'b0010, 1);

    // Multiply, or the reserved behaviour of op 16 when it is not built.
`ifdef ALU_MUL_EN
    applyStimulus("mul ovf", MUL, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 4'b1001, 33);
    applyStimulus("mul small", MUL, 32'h0000_FFFF, 32'h0000_0003, 1'b0, 32'h0002_FFFD, 4'b0000, 33);
`else
    applyStimulus("mul off a", MUL, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 4'b1000, 1);
    applyStimulus("mul off b", MUL, 32'h0000_FFFF, 32'h0000_0003, 1'b0, 32'h0000_0000, 4'b1000, 1);
`endif

    // Backpressure: result must hold and no new request may be taken.
    waitIdle("bp drain");
    out_ready = 1'b0;
    applyStimulus("bp add", ADD, 32'd1, 32'd1, 1'b0, 32'd2, 4'b0000, 1);
    op       = ADD;
    input_a  = 32'd7;
    input_b  = 32'd8;
    cin      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("bp alu_out hold", alu_out, 32'd2);
      checkOutput("bp flags hold", 32'(flags), 32'd0);
      checkOutput("bp in_ready low", 32'(in_ready), 32'd0);
      checkOutput("bp out_valid high", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("bp after handshake in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp after handshake out_valid", 32'(out_valid), 32'd0);
    @(posedge clock);
    #1;
    pushExpected("bp next add", 32'd15, 4'b0000, 1);
    in_valid = 1'b0;

    // Reset in the middle of a multiply.
    waitIdle("abort");
    op       = MUL;
    input_a  = 32'd5;
    input_b  = 32'd7;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
`ifndef ALU_MUL_EN
    pushExpected("abort op16 off", 32'd0, 4'b1000, 1);
`endif
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort alu_out", alu_out, 32'd0);
    checkOutput("abort flags", 32'(flags), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("abort release in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort release out_valid", 32'(out_valid), 32'd0);
    applyStimulus("add after abort", ADD, 32'd2, 32'd3, 1'b0, 32'd5, 4'b0000, 1);

    // Drain the scoreboard; anything left over never came out.
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput({e.name, " missing result"}, 32'd0, 32'd1);
    end

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
